// File: rtl/freq_gate_pkg.sv
// freq_gate_pkg: shared FSM encoding and default sizing for the gated edge counter
package freq_gate_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1, HOLD = 2'd2} state_t;
    localparam int unsigned GATE_CYCLES_DEF = 20000000;
    localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/sig_edge_sync.sv
// sig_edge_sync: synchronises an async input and emits a one-cycle rising-edge pulse
module sig_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic dly;
    // shift the async input through the synchroniser, then one extra delay flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            dly  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig};
            dly  <= sync[SYNC_STAGES-1];
        end
    end
    assign rise = sync[SYNC_STAGES-1] & ~dly;
endmodule

// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts SIG_IN rising edges over a fixed gate; optional saturation/OVF via FREQ_GATE_OVF_EN
module freq_gate_counter
    import freq_gate_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
`ifdef FREQ_GATE_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int TW = $clog2(GATE_CYCLES) + 1;
    localparam logic [TW-1:0] LOAD = TW'(GATE_CYCLES - 1);
    state_t state;
    logic [TW-1:0] timer;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic rise;
    sig_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .sig (sig_in),
        .rise(rise)
    );
`ifdef FREQ_GATE_OVF_EN
    logic sat;
    assign sat      = &cnt;
    assign cnt_next = cnt + CNT_W'(rise & ~sat);
    // flag edges that arrive while the counter is pinned at its maximum
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (state == IDLE && start)
            ovf <= 1'b0;
        else if (state == GATE && rise && sat)
            ovf <= 1'b1;
    end
`else
    assign cnt_next = cnt + CNT_W'(rise);
`endif
    // measurement FSM: arm on START, count through the gate, hold result until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= GATE;
                    timer <= LOAD;
                    cnt   <= '0;
                end
                GATE: begin
                    cnt <= cnt_next;
                    if (timer == '0) begin
                        result <= cnt_next;
                        state  <= HOLD;
                    end else
                        timer <= timer - TW'(1);
                end
                HOLD: if (result_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign busy         = state != IDLE;
    assign result_valid = state == HOLD;
endmodule

// File: tb/tb_freq_gate_counter.sv
// tb_freq_gate_counter: scoreboard bench for freq_gate_counter (GATE_CYCLES=100, CNT_W=4)
module tb_freq_gate_counter;
    localparam int unsigned G = 100;
    localparam int CW = 4;
    localparam int MAXV = (1 << CW) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig_in = 1'b0;
    logic start = 1'b0;
    logic result_ready = 1'b1;
    logic busy, result_valid;
    logic [CW-1:0] result;
`ifdef FREQ_GATE_OVF_EN
    logic ovf;
`endif
    int total = 0;
    int bad = 0;
    typedef struct {
        logic [CW-1:0] res;
        logic          ovf;
    } exp_t;
    exp_t q[$];
    logic arr[0:G];

    freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .sig_in(sig_in),
        .start(start),
        .busy(busy),
        .result(result),
        .result_valid(result_valid),
        .result_ready(result_ready)
`ifdef FREQ_GATE_OVF_EN
        ,
        .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // scoreboard consumer: compare every valid cycle, retire the entry on handshake
    always begin
        @(negedge clk);
        #1;
        if (!rst && result_valid) begin
            check("sb_pending", q.size() != 0, 1);
            if (q.size() != 0) begin
                check("result", result, q[0].res);
`ifdef FREQ_GATE_OVF_EN
                check("ovf", ovf, q[0].ovf);
`endif
                if (result_ready) q.delete(0);
            end
        end
    end

    // one full measurement: kind selects the SIG_IN pattern, hold delays RESULT_READY
    task automatic run(input int kind, input int hold);
        int c;
        logic ok;
        exp_t e;
        for (int j = 0; j <= G; j++)
            arr[j] = kind == 0 ? logic'((j % 10) >= 5) :
                     kind == 1 ? 1'b0 :
                     kind == 2 ? logic'((j % 4) >= 2) :
                     kind == 3 ? logic'(j >= G - 1) :
                     kind == 4 ? logic'(j >= G - 3) :
                     logic'($urandom_range(0, 1));
        c = 0;
        for (int j = 0; j <= G - 2; j++)
            if (arr[j] && (j == 0 || !arr[j-1])) c++;
`ifdef FREQ_GATE_OVF_EN
        e.res = c > MAXV ? CW'(MAXV) : CW'(c);
        e.ovf = c > MAXV;
`else
        e.res = CW'(c);
        e.ovf = 1'b0;
`endif
        q.push_back(e);
        result_ready = hold == 0;
        start = 1'b1;
        sig_in = arr[0];
        @(negedge clk);
        start = 1'b0;
        ok = 1'b1;
        for (int j = 1; j <= G; j++) begin
            ok &= busy && !result_valid;
            sig_in = arr[j];
            @(negedge clk);
        end
        check("gate_busy", ok, 1);
        sig_in = 1'b0;
        check("valid_rise", result_valid, 1);
        check("busy_hold", busy, 1);
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            ok &= busy && result_valid;
            start = (i % 2) == 1;
            @(negedge clk);
        end
        if (hold > 0) check("hold_stable", ok, 1);
        result_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("valid_fall", result_valid, 0);
        check("busy_idle", busy, 0);
        check("result_keep", result, e.res);
        repeat (3) @(negedge clk);
        check("start_ignored", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_result", result, 0);
`ifdef FREQ_GATE_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run(0, 0);
        run(1, 0);
        run(0, 20);
        run(2, 0);
        run(3, 0);
        run(4, 0);
        run(5, 3);
        run(0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j < 40; j++) begin
            sig_in = (j % 10) >= 5;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", result_valid, 0);
        check("midrst_result", result, 0);
        sig_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run(0, 0);
        repeat (2) @(negedge clk);
        check("sb_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
